// File: rtl/fir_seq_ctrl.sv
// Sequencer for the 15-tap FIR: divider-based sample strobe, bank select with flush/warm-up, output qualification.
// All outputs registered (one clock after the deciding edge); no backpressure, i_run=0 stops everything next clock.
module fir_seq_ctrl #(
    parameter int DIV_W      = 16,
    parameter int TAPS       = 15,
    parameter int PIPE_LAT   = 4,
    parameter int CLR_CYCLES = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    input  logic [1:0]       i_bank_req,
    input  logic             i_bank_req_vld,
    output logic             o_fir_en,
    output logic             o_fir_srst,
    output logic [1:0]       o_bank_sel,
    output logic             o_out_valid,
    output logic             o_busy
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int WRM_W = $clog2(TAPS);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WARM, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [WRM_W-1:0]    warm_cnt_q, warm_cnt_d;
    logic [1:0]          pend_q, pend_d;
    logic [1:0]          bank_q, bank_d;
    logic                en_q, en_d;
    logic                qual_q, qual_d;
    logic                srst_q, busy_q;
    logic [PIPE_LAT-1:0] vld_pipe_q;
    logic                flush, tick;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        warm_cnt_d = warm_cnt_q;
        pend_d     = i_bank_req_vld ? i_bank_req : pend_q;
        bank_d     = bank_q;
        en_d       = 1'b0;
        qual_d     = 1'b0;
        flush      = 1'b0;
        tick       = (div_cnt_q >= i_div);

        if (!i_run) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: flush = 1'b1;
                S_CLEAR: begin
                    // Any request while clearing restarts the clear from scratch.
                    if (i_bank_req_vld)
                        flush = 1'b1;
                    else if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1))
                        state_d = S_WARM;
                    else
                        clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
                default: begin
                    if (i_bank_req_vld && (i_bank_req != bank_q)) begin
                        flush = 1'b1;
                    end else begin
                        en_d      = tick;
                        qual_d    = tick && (state_q == S_RUN);
                        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                        if (tick && (state_q == S_WARM)) begin
                            if (warm_cnt_q == WRM_W'(TAPS - 2))
                                state_d = S_RUN;
                            else
                                warm_cnt_d = warm_cnt_q + WRM_W'(1);
                        end
                    end
                end
            endcase
        end

        if (flush) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
            bank_d    = pend_d;
        end
        if (flush || (state_d == S_IDLE)) begin
            div_cnt_d  = '0;
            warm_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            clr_cnt_q  <= '0;
            warm_cnt_q <= '0;
            pend_q     <= 2'b00;
            bank_q     <= 2'b00;
            en_q       <= 1'b0;
            qual_q     <= 1'b0;
            srst_q     <= 1'b0;
            busy_q     <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            pend_q     <= pend_d;
            bank_q     <= bank_d;
            en_q       <= en_d;
            qual_q     <= qual_d;
            srst_q     <= (state_d == S_CLEAR);
            busy_q     <= (state_d == S_CLEAR) || (state_d == S_WARM);
            // Flushing or stopping squashes outputs still in flight from the old bank.
            if (flush || (state_d == S_IDLE))
                vld_pipe_q <= '0;
            else
                vld_pipe_q <= PIPE_LAT'({vld_pipe_q, qual_q});
        end
    end

    assign o_fir_en    = en_q;
    assign o_fir_srst  = srst_q;
    assign o_bank_sel  = bank_q;
    assign o_out_valid = vld_pipe_q[PIPE_LAT-1];
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed scenarios with literal timing expectations, then random traffic
// checked every cycle against an event-level model (strobe timing plus a queue of due valid cycles).
module tb_fir_seq_ctrl;

    localparam int TAPS       = 15;
    localparam int PIPE_LAT   = 4;
    localparam int CLR_CYCLES = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_run = 1'b0;
    logic [15:0] i_div = 16'd0;
    logic [1:0]  i_bank_req = 2'b00;
    logic        i_bank_req_vld = 1'b0;
    logic        o_fir_en, o_fir_srst, o_out_valid, o_busy;
    logic [1:0]  o_bank_sel;

    int errors = 0;
    int checks = 0;

    fir_seq_ctrl #(
        .DIV_W(16), .TAPS(TAPS), .PIPE_LAT(PIPE_LAT), .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_run         (i_run),
        .i_div         (i_div),
        .i_bank_req    (i_bank_req),
        .i_bank_req_vld(i_bank_req_vld),
        .o_fir_en      (o_fir_en),
        .o_fir_srst    (o_fir_srst),
        .o_bank_sel    (o_bank_sel),
        .o_out_valid   (o_out_valid),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modes 0 idle, 1 clearing, 2 warming, 3 running.
    int          m_mode = 0;
    int          m_clr = 0;
    int          m_ticks = 0;
    int          m_nstr = 0;
    logic [1:0]  m_pend = 2'b00;
    logic [1:0]  m_bank = 2'b00;
    logic        m_en = 1'b0;
    logic        m_vld = 1'b0;
    int          m_due[$];
    int          cyc = 0;

    task automatic m_flush(input logic [1:0] b);
        m_mode = 1;
        m_clr  = 1;
        m_bank = b;
        m_due.delete();
    endtask

    always @(posedge clk or posedge i_rst) begin
        logic [1:0] pend_n;
        cyc++;
        if (i_rst) begin
            m_mode = 0; m_clr = 0; m_ticks = 0; m_nstr = 0;
            m_pend = 2'b00; m_bank = 2'b00; m_en = 1'b0; m_vld = 1'b0;
            m_due.delete();
        end else begin
            pend_n = i_bank_req_vld ? i_bank_req : m_pend;
            m_en = 1'b0;
            if (!i_run) begin
                m_mode = 0;
                m_due.delete();
            end else if (m_mode == 0) begin
                m_flush(pend_n);
            end else if (m_mode == 1) begin
                if (i_bank_req_vld) m_flush(pend_n);
                else if (m_clr == CLR_CYCLES) begin m_mode = 2; m_ticks = 0; m_nstr = 0; end
                else m_clr++;
            end else if (i_bank_req_vld && i_bank_req != m_bank) begin
                m_flush(i_bank_req);
            end else if (m_ticks >= int'(i_div)) begin
                m_en = 1'b1;
                m_ticks = 0;
                if (m_mode == 3) m_due.push_back(cyc + PIPE_LAT);
                else begin
                    m_nstr++;
                    if (m_nstr == TAPS - 1) m_mode = 3;
                end
            end else begin
                m_ticks++;
            end
            m_pend = pend_n;
            m_vld = (m_due.size() > 0) && (m_due[0] == cyc);
            if (m_vld) void'(m_due.pop_front());
        end
    end

    always @(negedge clk) begin
        check("en",    o_fir_en,    m_en);
        check("srst",  o_fir_srst,  m_mode == 1);
        check("busy",  o_busy,      (m_mode == 1) || (m_mode == 2));
        check("bank",  o_bank_sel,  m_bank);
        check("valid", o_out_valid, m_vld);
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (!o_out_valid && n < budget) begin step; n++; end
        check(nm, o_out_valid, 1'b1);
    endtask

    initial begin
        int en_t[$];
        int vl_t[$];
        int srst_n, last_srst, n, nv, ne;

        repeat (3) step;
        check("rst_en",   o_fir_en, 0);
        check("rst_srst", o_fir_srst, 0);
        check("rst_vld",  o_out_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_bank", o_bank_sel, 0);

        // Start-up with i_div=9.
        i_rst = 1'b0; i_run = 1'b1; i_div = 16'd9;
        srst_n = 0; last_srst = 0;
        for (int k = 0; k < 200; k++) begin
            step;
            if (o_fir_srst) begin srst_n++; last_srst = k; end
            if (o_fir_en) en_t.push_back(k);
            if (o_out_valid) vl_t.push_back(k);
        end
        check("s1_srst_len", srst_n, 4);
        check("s1_en_count", en_t.size(), 19);
        check("s1_vld_count", vl_t.size(), 5);
        if (en_t.size() >= 15 && vl_t.size() >= 2) begin
            check("s1_first_en", en_t[0] - last_srst, 11);
            check("s1_en_period", en_t[1] - en_t[0], 10);
            check("s1_first_vld", vl_t[0] - en_t[14], 4);
            check("s1_vld_period", vl_t[1] - vl_t[0], 10);
        end

        // Bank change 0 -> 2 in RUN with i_div=3.
        i_div = 16'd3;
        repeat (8) step;
        i_bank_req = 2'd2; i_bank_req_vld = 1'b1;
        step;
        i_bank_req_vld = 1'b0;
        check("s2_srst", o_fir_srst, 1);
        check("s2_bank", o_bank_sel, 2);
        ne = 0; n = 0;
        while (n < 300) begin
            step; n++;
            if (o_out_valid) break;
            if (o_fir_en) ne++;
        end
        check("s2_vld_back", o_out_valid, 1);
        check("s2_strobes", ne, 15);

        // Same-bank request: no flush, no gap.
        step;
        i_bank_req = 2'd2; i_bank_req_vld = 1'b1;
        step;
        i_bank_req_vld = 1'b0;
        n = 0; nv = 0; ne = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_fir_srst) n++;
            if (o_out_valid) nv++;
            if (o_fir_en) ne++;
            step;
        end
        check("s3_no_srst", n, 0);
        check("s3_vlds", nv, 5);
        check("s3_ens", ne, 5);

        // i_div=0 in RUN.
        i_div = 16'd0;
        repeat (8) step;
        nv = 0; ne = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_out_valid) nv++;
            if (o_fir_en) ne++;
            step;
        end
        check("s4_vld_cont", nv, 10);
        check("s4_en_cont", ne, 10);

        // Restart of CLEAR by a request in its second cycle.
        i_bank_req = 2'd1; i_bank_req_vld = 1'b1;
        step;
        n = o_fir_srst ? 1 : 0;
        i_bank_req_vld = 1'b0;
        step;
        if (o_fir_srst) n++;
        i_bank_req = 2'd3; i_bank_req_vld = 1'b1;
        step;
        if (o_fir_srst) n++;
        i_bank_req_vld = 1'b0;
        repeat (10) begin step; if (o_fir_srst) n++; end
        check("s5_srst_len", n, 6);
        check("s5_bank", o_bank_sel, 3);

        // Stop coinciding with a bank request.
        wait_valid("s6_reach_run", 100);
        i_run = 1'b0; i_bank_req = 2'd1; i_bank_req_vld = 1'b1;
        step;
        i_bank_req_vld = 1'b0;
        check("s6_busy", o_busy, 0);
        check("s6_bank_hold", o_bank_sel, 3);
        n = 0;
        repeat (10) begin step; if (o_fir_en || o_out_valid) n++; end
        check("s6_quiet", n, 0);
        i_run = 1'b1;
        step;
        check("s6_bank_new", o_bank_sel, 1);
        check("s6_srst", o_fir_srst, 1);

        // Asynchronous reset in the middle of WARM.
        n = 0;
        while (!(o_busy && !o_fir_srst) && n < 50) begin step; n++; end
        check("s7_in_warm", o_busy && !o_fir_srst, 1);
        repeat (2) step;
        #2 i_rst = 1'b1;
        #1;
        check("s7_en",   o_fir_en, 0);
        check("s7_busy", o_busy, 0);
        check("s7_vld",  o_out_valid, 0);
        check("s7_srst", o_fir_srst, 0);
        check("s7_bank", o_bank_sel, 0);
        step;
        #2 i_rst = 1'b0;

        // Random traffic, checked by the model every cycle.
        for (int k = 0; k < 4000; k++) begin
            step;
            i_bank_req_vld = ($urandom_range(0, 119) == 0);
            i_bank_req     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) i_div = 16'($urandom_range(0, 6));
            if (i_run) begin
                if ($urandom_range(0, 299) == 0) i_run = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                i_run = 1'b1;
            end
        end
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer for the 15-tap pipelined FIR datapath. Generates the per-sample enable strobe from a programmable clock divider and selects the coefficient bank (6 kHz / 8 kHz / 18 kHz / spare). On every start and every bank change it flushes the filter, then suppresses outputs until the tap line holds only post-flush samples. It also produces an output-valid strobe aligned to the filter's output pipeline. It sits between the sample source/host control and the FIR instance: it drives the filter's enable, synchronous clear and bank select, and qualifies its output.

## Interface
- DIV_W, 16, width of the sample-period divider
- TAPS, 15, filter tap count; warm-up length is TAPS-1 strobes
- PIPE_LAT, 4, clocks from an accepted input sample to the corresponding filter output
- CLR_CYCLES, 4, clocks the filter clear is held asserted
- clk  in  1  system clock; single clock domain
- i_rst  in  1  asynchronous, active-high reset
- i_run  in  1  level; 1 = filtering enabled
- i_div  in  DIV_W  sample period minus one, in clocks
- i_bank_req  in  2  requested coefficient bank
- i_bank_req_vld  in  1  one-cycle request qualifier
- o_fir_en  out  1  sample strobe to the filter (one clock wide)
- o_fir_srst  out  1  synchronous clear to the filter
- o_bank_sel  out  2  active coefficient bank
- o_out_valid  out  1  filter output is a valid, fully-warmed sample
- o_busy  out  1  high in CLEAR or WARM

## Operation
- States:
  - IDLE: no strobes; divider counter held at 0.
  - CLEAR: o_fir_srst=1; clear counter runs.
  - WARM: strobes active; counts TAPS-1 strobes.
  - RUN: strobes active; outputs qualified.
- Transitions:
  - IDLE→CLEAR when i_run=1.
  - CLEAR→WARM after CLR_CYCLES clocks.
  - WARM→RUN on the (TAPS-1)th strobe.
  - CLEAR/WARM/RUN→IDLE when i_run=0. Stop has priority over every other event.
- Bank handling:
  - A request with i_bank_req_vld=1 is latched into a pending register in any state, including IDLE.
  - o_bank_sel takes the pending value on entry to CLEAR.
  - RUN or WARM: a request for a bank different from o_bank_sel goes to CLEAR on the next clock.
  - RUN or WARM: a request equal to o_bank_sel is ignored (no flush).
  - CLEAR: a request updates the pending bank and reloads the clear counter, so CLEAR restarts with a full CLR_CYCLES.
- Divider:
  - Counter increments each clock in WARM/RUN.
  - When cnt >= i_div: o_fir_en=1 for that clock and cnt returns to 0.
  - i_div is sampled live. Lowering i_div below the current count gives an immediate strobe.
  - i_div=0 gives a strobe every clock.
  - The counter is zeroed on entry to CLEAR and in IDLE.
- Output valid:
  - A PIPE_LAT-deep shift line carries (o_fir_en & state==RUN). o_out_valid is its last stage.
  - The shift line is cleared on entry to CLEAR and to IDLE, which squashes in-flight outputs from the old bank.
  - The (TAPS-1)th WARM strobe is not qualified. The first strobe issued in RUN is the first qualified one.

## Timing
- All flops reset asynchronously:
  - State = IDLE.
  - o_fir_en=0, o_fir_srst=0, o_out_valid=0, o_busy=0.
  - o_bank_sel=2'b00, pending bank=2'b00, counters=0.
- Outputs are registered and change only on rising clk.
- o_fir_srst is asserted in the first clock after the CLEAR entry decision and stays high exactly CLR_CYCLES clocks, unless CLEAR is restarted.
- First strobe: cnt starts at 0 on WARM entry, so the first strobe occurs i_div+1 clocks after WARM entry.
- Strobe in cycle t → o_out_valid in cycle t+PIPE_LAT, if the strobe was issued in RUN.
- o_fir_en is never high while o_fir_srst is high.
- o_busy = (state==CLEAR || state==WARM).
- Reset mid-operation: all outputs are forced to reset values immediately. The pending bank is lost.

## Test plan
- Reset release, i_run=1, i_div=9:
  - o_fir_srst high 4 clocks.
  - Strobes every 10 clocks.
  - First o_out_valid 4 clocks after the 15th strobe (the first RUN strobe), then every 10 clocks.
- In RUN, i_div=3, bank request 2 (≠ current 0):
  - Next clock CLEAR; o_bank_sel=2; srst 4 clocks.
  - Any o_out_valid pending within the last 4 clocks never appears.
  - 14 WARM strobes, then valid resumes.
- In RUN, bank request equal to the current bank: no srst, no gap in strobes or valids.
- i_div=0: o_fir_en high every clock in WARM/RUN. In RUN, o_out_valid is continuously high after PIPE_LAT.
- During CLEAR (2nd cycle), request bank 3: srst extends to 4 clocks from the request; o_bank_sel=3.
- i_run drops the same clock as a bank request:
  - IDLE next clock; all strobes and valids stop; pending bank latched.
  - On the next i_run=1, o_bank_sel shows the latched bank.
- Async i_rst pulse mid-WARM: outputs return to reset values without waiting for a clock edge.
